// File: rtl/sync_fifo_native_pkg.sv
// Shared constants and helpers for the native-interface synchronous FIFO.
package fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    // Occupancy needs one bit more than a pointer so that DEPTH itself is representable.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_native_if.sv
// Native wr_en/rd_en FIFO bus: producer/consumer side is master, FIFO is slave.
interface sync_fifo_native_if
    import fifo_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 32
);
    localparam int CW = cnt_w(DEPTH);

    logic              wr_en;
    logic [DATA_W-1:0] din;
    logic              rd_en;
    logic [DATA_W-1:0] dout;
    logic              valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [CW-1:0]     count;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr_en, din, rd_en,
        input  dout, valid, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  wr_en, din, rd_en,
        output dout, valid, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

endinterface

// File: rtl/sync_fifo_native_ptr_ctrl.sv
// Pointer, occupancy, status-flag and sticky error-flag registers of the FIFO.
module fifo_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter  int DEPTH     = 32,
    parameter  int AF_THRESH = DEPTH - 4,
    parameter  int AE_THRESH = 4,
    localparam int PW        = $clog2(DEPTH),
    localparam int CW        = cnt_w(DEPTH)
) (
    input  logic          clk,
    input  logic          srst_n,
    input  logic          wr_en,
    input  logic          rd_en,
    output logic          wr_ok,
    output logic          rd_ok,
    output logic [PW-1:0] wr_ptr,
    output logic [PW-1:0] rd_ptr,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic          overflow,
    output logic          underflow
);

    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C   = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C   = CW'(AE_THRESH);

    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_nxt;
    logic          full_q, empty_q, af_q, ae_q, ovf_q, unf_q;

    always_comb begin
        wr_ok     = wr_en && !full_q;
        rd_ok     = rd_en && !empty_q;
        count_nxt = count_q;
        case ({wr_ok, rd_ok})
            2'b10:   count_nxt = count_q + CW'(1);
            2'b01:   count_nxt = count_q - CW'(1);
            default: count_nxt = count_q;
        endcase
    end

    // Flags are registered from the post-update count so they never lag the occupancy.
    always_ff @(posedge clk) begin
        if (!srst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (rd_ok) rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_nxt;
            full_q  <= (count_nxt == FULL_C);
            empty_q <= (count_nxt == '0);
            af_q    <= (count_nxt >= AF_C);
            ae_q    <= (count_nxt <= AE_C);
            if (wr_en && full_q)  ovf_q <= 1'b1;
            if (rd_en && empty_q) unf_q <= 1'b1;
        end
    end

    assign wr_ptr       = wr_ptr_q;
    assign rd_ptr       = rd_ptr_q;
    assign count        = count_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: rtl/sync_fifo_native.sv
// Generic-width synchronous FIFO with native interface; storage array and read-data path.
module sync_fifo_native
    import fifo_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int DEPTH     = 32,
    parameter int FWFT      = FIFO_STD,
    parameter int AF_THRESH = DEPTH - 4,
    parameter int AE_THRESH = 4
) (
    input  logic               clk,
    input  logic               srst_n,
    sync_fifo_native_if.slave  bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_ok, rd_ok;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              full, empty, almost_full, almost_empty, overflow, underflow;

    fifo_ptr_ctrl #(
        .DEPTH     (DEPTH),
        .AF_THRESH (AF_THRESH),
        .AE_THRESH (AE_THRESH)
    ) u_ctrl (
        .clk          (clk),
        .srst_n       (srst_n),
        .wr_en        (bus.wr_en),
        .rd_en        (bus.rd_en),
        .wr_ok        (wr_ok),
        .rd_ok        (rd_ok),
        .wr_ptr       (wr_ptr),
        .rd_ptr       (rd_ptr),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always_ff @(posedge clk) begin
        if (srst_n && wr_ok) mem[wr_ptr] <= bus.din;
    end

    if (FWFT == FIFO_FWFT) begin : g_fwft
        // Head word is presented combinationally; rd_en only acknowledges it.
        logic unused_rd_ok;
        assign unused_rd_ok = rd_ok;
        assign bus.dout     = empty ? '0 : mem[rd_ptr];
        assign bus.valid    = !empty;
    end else begin : g_std
        logic [DATA_W-1:0] dout_q;
        logic              valid_q;
        always_ff @(posedge clk) begin
            if (!srst_n) begin
                dout_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= rd_ok;
                if (rd_ok) dout_q <= mem[rd_ptr];
            end
        end
        assign bus.dout  = dout_q;
        assign bus.valid = valid_q;
    end

    assign bus.count        = count;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = almost_full;
    assign bus.almost_empty = almost_empty;
    assign bus.overflow     = overflow;
    assign bus.underflow    = underflow;

endmodule

// File: tb/tb_sync_fifo_native.sv
// Drives a standard-mode and an FWFT-mode FIFO with identical stimulus against a queue model.
module tb_sync_fifo_native;
    import fifo_pkg::*;

    localparam int DW    = 64;
    localparam int DEPTH = 32;
    localparam int AF    = DEPTH - 4;
    localparam int AE    = 4;

    logic clk = 1'b0;
    logic srst_n = 1'b0;
    always #5 clk = ~clk;

    sync_fifo_native_if #(.DATA_W(DW), .DEPTH(DEPTH)) if_std ();
    sync_fifo_native_if #(.DATA_W(DW), .DEPTH(DEPTH)) if_fwft ();

    sync_fifo_native #(
        .DATA_W(DW), .DEPTH(DEPTH), .FWFT(FIFO_STD), .AF_THRESH(AF), .AE_THRESH(AE)
    ) u_std (.clk(clk), .srst_n(srst_n), .bus(if_std));

    sync_fifo_native #(
        .DATA_W(DW), .DEPTH(DEPTH), .FWFT(FIFO_FWFT), .AF_THRESH(AF), .AE_THRESH(AE)
    ) u_fwft (.clk(clk), .srst_n(srst_n), .bus(if_fwft));

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: contents as a queue, sticky errors, standard-mode output register.
    logic [DW-1:0] q[$];
    bit            m_ovf, m_unf, m_svalid;
    logic [DW-1:0] m_sdout;

    task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        int sz = q.size();
        logic [DW-1:0] head = (sz != 0) ? q[0] : '0;
        check_eq("std_count", DW'(if_std.count), DW'(sz));
        check_eq("std_full",  DW'(if_std.full),  DW'(sz == DEPTH));
        check_eq("std_empty", DW'(if_std.empty), DW'(sz == 0));
        check_eq("std_af",    DW'(if_std.almost_full),  DW'(sz >= AF));
        check_eq("std_ae",    DW'(if_std.almost_empty), DW'(sz <= AE));
        check_eq("std_ovf",   DW'(if_std.overflow),  DW'(m_ovf));
        check_eq("std_unf",   DW'(if_std.underflow), DW'(m_unf));
        check_eq("std_valid", DW'(if_std.valid), DW'(m_svalid));
        check_eq("std_dout",  if_std.dout, m_sdout);
        check_eq("fw_count",  DW'(if_fwft.count), DW'(sz));
        check_eq("fw_full",   DW'(if_fwft.full),  DW'(sz == DEPTH));
        check_eq("fw_empty",  DW'(if_fwft.empty), DW'(sz == 0));
        check_eq("fw_ovf",    DW'(if_fwft.overflow),  DW'(m_ovf));
        check_eq("fw_unf",    DW'(if_fwft.underflow), DW'(m_unf));
        check_eq("fw_valid",  DW'(if_fwft.valid), DW'(sz != 0));
        check_eq("fw_dout",   if_fwft.dout, head);
    endtask

    task automatic step(input bit rst, input bit w, input logic [DW-1:0] d, input bit r);
        int sz;
        bit wr_ok, rd_ok;
        @(negedge clk);
        srst_n        = !rst;
        if_std.wr_en  = w;  if_fwft.wr_en = w;
        if_std.din    = d;  if_fwft.din   = d;
        if_std.rd_en  = r;  if_fwft.rd_en = r;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_ovf = 0; m_unf = 0; m_svalid = 0; m_sdout = '0;
        end else begin
            sz    = q.size();
            wr_ok = w && (sz < DEPTH);
            rd_ok = r && (sz > 0);
            if (w && !wr_ok) m_ovf = 1;
            if (r && !rd_ok) m_unf = 1;
            m_svalid = rd_ok;
            if (rd_ok) m_sdout = q.pop_front();
            if (wr_ok) q.push_back(d);
        end
        #1;
        check_all();
    endtask

    function automatic logic [DW-1:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        if_std.wr_en = 0; if_std.rd_en = 0; if_std.din = '0;
        if_fwft.wr_en = 0; if_fwft.rd_en = 0; if_fwft.din = '0;

        // Reset (with requests asserted, which reset must override), then idle.
        step(1, 1, 64'h1234, 1);
        step(1, 0, '0, 0);
        repeat (3) step(0, 0, '0, 0);

        // Fill to 20, then stream read+write: count holds at 20, data in order.
        for (int i = 0; i < 20; i++) step(0, 1, DW'(i), 0);
        for (int i = 20; i < 32; i++) step(0, 1, DW'(i), 1);

        // Top up to full, then attempt one more write (99) which must be dropped.
        for (int i = 0; i < 12; i++) step(0, 1, DW'(100 + i), 0);
        step(0, 1, DW'(99), 0);
        step(0, 1, DW'(99), 1);
        for (int i = 0; i < 34; i++) step(0, 0, '0, 1);

        // Read with a write in the same cycle on an empty FIFO.
        step(1, 0, '0, 0);
        step(0, 1, DW'(7), 1);
        step(0, 0, '0, 1);
        step(0, 0, '0, 0);

        // FWFT presentation of a single word, then acknowledge it.
        step(0, 1, DW'('hA5), 0);
        step(0, 0, '0, 0);
        step(0, 0, '0, 1);
        step(0, 0, '0, 0);

        // Randomised interleaving across the full occupancy range.
        for (int ph = 0; ph < 6; ph++) begin
            int wp = (ph % 2 == 0) ? 75 : 25;
            int rp = (ph % 2 == 0) ? 30 : 80;
            for (int i = 0; i < 60; i++)
                step(0, $urandom_range(0, 99) < wp, rnd64(), $urandom_range(0, 99) < rp);
            if (ph == 3) step(1, 1, rnd64(), 1);
        end
        for (int i = 0; i < 40; i++) step(0, 0, '0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
